multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main sequencer for the multi-cycle CPU datapath.
- Steps each instruction through fetch, decode, execute, memory and write-back states.
- Drives ALUop into the ALU control decoder, plus all datapath enables and mux selects.
- Handshakes with a shared single-port memory via req/ready; counts retired instructions.

Parameters:
- OPW, 4, opcode width.
- CNTW, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  OPW  opcode field of the instruction register; sampled in DECODE.
- zero  in  1  ALU zero flag; valid in BRANCH.
- mem_ready  in  1  memory completion strobe for the current request.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  request is a write.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load instruction register.
- pc_write  out  1  unconditional PC load.
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = regB, 01 = constant 1, 10 = sign-extended immediate.
- alu_op  out  3  to ALU control: 000 R-type (func decoded there), 010 add, 011 sub, 110 and, 111 or.
- reg_write  out  1  register file write.
- reg_dst  out  1  destination select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- halted  out  1  core stopped on HALT.
- illegal  out  1  core stopped on an undefined opcode.
- retired  out  CNTW  count of completed instructions.

Behaviour:
- Opcodes: 0000 R-type, 0001 ADDI, 0010 ANDI, 0011 ORI, 0100 LW, 0101 SW, 0110 BEQ, 0111 J, 1111 HALT. All others are illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU_R, WB_ALU_I, WB_MEM, BRANCH, JUMP, HALT, ILLEGAL.
- Outputs are Moore-decoded from the state register. Every enable is 0 and every select 0 unless listed below.
- Reset (rst_n low, asynchronous): state = FETCH, retired = 0, all outputs 0.
- FETCH:
  - Outputs: mem_req = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 010.
  - Stay in FETCH while mem_ready = 0.
  - On mem_ready: ir_write = 1 and pc_write = 1 (pc_src = 00) in that same cycle (Mealy-qualified by mem_ready), then go to DECODE.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 10, alu_op = 010 (precompute branch target).
  - Next state by opcode: R -> EXEC_R; ADDI/ANDI/ORI -> EXEC_I; LW/SW -> MEM_ADDR; BEQ -> BRANCH; J -> JUMP; HALT -> HALT; other -> ILLEGAL.
- EXEC_R: alu_src_a = 1, alu_src_b = 00, alu_op = 000; next WB_ALU_R.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, alu_op = 010/110/111 for ADDI/ANDI/ORI. The opcode is latched in DECODE. Next WB_ALU_I.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 010; next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD:
  - Outputs: mem_req = 1, iord = 1.
  - Wait for mem_ready, then go to WB_MEM.
- MEM_WR:
  - Outputs: mem_req = 1, mem_we = 1, iord = 1.
  - Wait for mem_ready, then go to FETCH and increment retired.
- WB_ALU_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0.
- WB_ALU_I: reg_write = 1, reg_dst = 0, mem_to_reg = 0.
- WB_MEM: reg_write = 1, reg_dst = 0, mem_to_reg = 1.
- All three write-back states go to FETCH and increment retired.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, alu_op = 011, pc_src = 01.
  - pc_write = zero (combinational qualification).
  - Next FETCH; retired increments.
- JUMP: pc_write = 1, pc_src = 10; next FETCH; retired increments.
- HALT: halted = 1, terminal. ILLEGAL: illegal = 1, terminal. Only rst_n leaves either state. retired does not count HALT or illegal opcodes.
- Retired instructions per opcode:
  - R/I-type: 4 cycles.
  - LW: 5 cycles + memory wait.
  - SW: 4 cycles + memory wait.
  - BEQ/J: 3 cycles.
  - Each memory access adds one cycle per cycle mem_ready stays low.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- mem_req and the address select stay stable while waiting.
- retired wraps modulo 2^CNTW with no saturation.
- Reset mid-access drops mem_req immediately. The memory must tolerate an abandoned request.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - the opcode constants;
  - the ALUop encodings (000/010/011/110/111), also used by the ALU control decoder;
  - the state enumeration;
  - the pc_src and alu_src_b encodings.
- Natural sub-module ctrl_out_decode: purely combinational state/opcode/zero/mem_ready -> control vector. The FSM register, opcode latch and counter stay in the top module.

Test Plan:
- Reset with rst_n low mid-MEM_RD (mem_req = 1) -> mem_req drops asynchronously; after release state = FETCH, retired = 0, all enables 0.
- R-type (0000), mem_ready tied high -> FETCH, DECODE, EXEC_R (alu_op = 000), WB_ALU_R (reg_write = 1, reg_dst = 1); retired = 1 after 4 cycles.
- LW (0100), mem_ready low 3 cycles in MEM_RD -> mem_req and iord = 1 held 4 cycles; WB_MEM has mem_to_reg = 1; 8 cycles total.
- BEQ (0110) with zero = 1, then with zero = 0 -> pc_write = 1 with pc_src = 01 and alu_op = 011 in the first case; pc_write = 0 in the second; 3 cycles each.
- ANDI (0010) then ORI (0011) -> alu_op = 110 then 111 in EXEC_I, reg_dst = 0 in write-back; retired = 2.
- Opcode 1010 -> ILLEGAL with illegal = 1, no further mem_req, retired unchanged. Opcode 1111 -> halted = 1, terminal. Preset retired = 0xFFFF plus one J -> retired = 0x0000.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path: opcodes, ALUop
// encodings, mux select encodings and the sequencer state enumeration.
package cpu_ctrl_pkg;

    localparam int OPCODE_BITS = 4;

    // Instruction opcodes
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_ANDI  = 4'b0010;
    localparam logic [3:0] OP_ORI   = 4'b0011;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_J     = 4'b0111;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // ALUop encodings, shared with the ALU control decoder
    localparam logic [2:0] ALU_OP_RTYPE = 3'b000;
    localparam logic [2:0] ALU_OP_ADD   = 3'b010;
    localparam logic [2:0] ALU_OP_SUB   = 3'b011;
    localparam logic [2:0] ALU_OP_AND   = 3'b110;
    localparam logic [2:0] ALU_OP_OR    = 3'b111;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // ALU B operand select
    localparam logic [1:0] ALUB_REGB = 2'b00;
    localparam logic [1:0] ALUB_ONE  = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU_R = 4'd7,
        S_WB_ALU_I = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_HALT     = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    // Successor of DECODE; any opcode bits above the defined field must be
    // zero for the instruction to be legal.
    function automatic state_t decode_next_state(input logic [3:0] op,
                                                 input logic op_hi_zero);
        state_t nxt;
        nxt = S_ILLEGAL;
        if (op_hi_zero) begin
            case (op)
                OP_RTYPE:                nxt = S_EXEC_R;
                OP_ADDI, OP_ANDI, OP_ORI: nxt = S_EXEC_I;
                OP_LW, OP_SW:            nxt = S_MEM_ADDR;
                OP_BEQ:                  nxt = S_BRANCH;
                OP_J:                    nxt = S_JUMP;
                OP_HALT:                 nxt = S_HALT;
                default:                 nxt = S_ILLEGAL;
            endcase
        end
        return nxt;
    endfunction

    // ALU operation for the immediate-format arithmetic/logic instructions
    function automatic logic [2:0] imm_alu_op(input logic [3:0] op);
        logic [2:0] aop;
        case (op)
            OP_ANDI: aop = ALU_OP_AND;
            OP_ORI:  aop = ALU_OP_OR;
            default: aop = ALU_OP_ADD;
        endcase
        return aop;
    endfunction

endpackage

// File: rtl/multicycle_control_ctrl_out_decode.sv
// Combinational control-vector decode for the multi-cycle sequencer. Outputs
// are Moore-decoded from the state, except the FETCH write enables (qualified
// by mem_ready) and the BRANCH PC write (qualified by zero).
module ctrl_out_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] state,
    input  logic [3:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       illegal
);

    state_t st;
    assign st = state_t'(state);

    // Decode the current state into datapath enables and selects
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_REGB;
        alu_op     = ALU_OP_RTYPE;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (st)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = ALUB_ONE;
                alu_op    = ALU_OP_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                pc_src    = PC_SRC_ALU;
            end
            S_DECODE: begin
                alu_src_b = ALUB_IMM;
                alu_op    = ALU_OP_ADD;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_REGB;
                alu_op    = ALU_OP_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = imm_alu_op(op);
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                alu_op    = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            S_WB_ALU_R: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_WB_ALU_I: begin
                reg_write = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_REGB;
                alu_op    = ALU_OP_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main sequencer for the multi-cycle CPU. Holds the state register, the opcode
// latch and the retired-instruction counter; the control vector is decoded by
// ctrl_out_decode and forced to zero while rst_n is low so an in-flight memory
// request is dropped the moment reset asserts. Assumes OPW >= 4.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            iord,
    output logic            ir_write,
    output logic            pc_write,
    output logic [1:0]      pc_src,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_op,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            halted,
    output logic            illegal,
    output logic [CNTW-1:0] retired
);

    state_t     state;
    logic [3:0] op_q;
    logic       op_hi_zero;

    logic       d_mem_req;
    logic       d_mem_we;
    logic       d_iord;
    logic       d_ir_write;
    logic       d_pc_write;
    logic [1:0] d_pc_src;
    logic       d_alu_src_a;
    logic [1:0] d_alu_src_b;
    logic [2:0] d_alu_op;
    logic       d_reg_write;
    logic       d_reg_dst;
    logic       d_mem_to_reg;
    logic       d_halted;
    logic       d_illegal;

    assign op_hi_zero = ((opcode >> OPCODE_BITS) == '0);

    // Sequencer state, opcode latch and retired-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            op_q    <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) state <= S_DECODE;
                end
                S_DECODE: begin
                    op_q  <= opcode[3:0];
                    state <= decode_next_state(opcode[3:0], op_hi_zero);
                end
                S_EXEC_R:   state <= S_WB_ALU_R;
                S_EXEC_I:   state <= S_WB_ALU_I;
                S_MEM_ADDR: state <= (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (mem_ready) state <= S_WB_MEM;
                end
                S_MEM_WR: begin
                    if (mem_ready) begin
                        state   <= S_FETCH;
                        retired <= retired + CNTW'(1);
                    end
                end
                S_WB_ALU_R, S_WB_ALU_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
                    state   <= S_FETCH;
                    retired <= retired + CNTW'(1);
                end
                S_HALT:    state <= S_HALT;
                S_ILLEGAL: state <= S_ILLEGAL;
                default:   state <= S_FETCH;
            endcase
        end
    end

    ctrl_out_decode u_decode (
        .state      (state),
        .op         (op_q),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (d_mem_req),
        .mem_we     (d_mem_we),
        .iord       (d_iord),
        .ir_write   (d_ir_write),
        .pc_write   (d_pc_write),
        .pc_src     (d_pc_src),
        .alu_src_a  (d_alu_src_a),
        .alu_src_b  (d_alu_src_b),
        .alu_op     (d_alu_op),
        .reg_write  (d_reg_write),
        .reg_dst    (d_reg_dst),
        .mem_to_reg (d_mem_to_reg),
        .halted     (d_halted),
        .illegal    (d_illegal)
    );

    assign mem_req    = rst_n & d_mem_req;
    assign mem_we     = rst_n & d_mem_we;
    assign iord       = rst_n & d_iord;
    assign ir_write   = rst_n & d_ir_write;
    assign pc_write   = rst_n & d_pc_write;
    assign pc_src     = rst_n ? d_pc_src : 2'b00;
    assign alu_src_a  = rst_n & d_alu_src_a;
    assign alu_src_b  = rst_n ? d_alu_src_b : 2'b00;
    assign alu_op     = rst_n ? d_alu_op : 3'b000;
    assign reg_write  = rst_n & d_reg_write;
    assign reg_dst    = rst_n & d_reg_dst;
    assign mem_to_reg = rst_n & d_mem_to_reg;
    assign halted     = rst_n & d_halted;
    assign illegal    = rst_n & d_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard testbench for multicycle_control. Each driven cycle pushes the
// expected control vector and retired count; a monitor pops and compares mid-cycle.
module tb_multicycle_control;

    localparam int TB_CNTW = 4;

    typedef enum {
        P_FETCH, P_DECODE, P_EXEC_R, P_EXEC_I, P_MEM_ADDR, P_MEM_RD, P_MEM_WR,
        P_WB_R, P_WB_I, P_WB_M, P_BRANCH, P_JUMP, P_HALT, P_ILL
    } phase_t;

    typedef struct {
        string        tag;
        logic [17:0]  vec;
        logic [TB_CNTW-1:0] ret;
    } sbEntry_t;

    logic               clk;
    logic               rst_n;
    logic [3:0]         opcode;
    logic               zero;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               ir_write;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_op;
    logic               reg_write;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               halted;
    logic               illegal;
    logic [TB_CNTW-1:0] retired;

    logic [17:0]        obsVec;
    sbEntry_t           sb[$];
    sbEntry_t           mon;
    logic [TB_CNTW-1:0] expRetired;
    logic [3:0]         latchedOp;
    int                 testsRun;
    int                 failCount;

    multicycle_control #(.OPW(4), .CNTW(TB_CNTW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .illegal    (illegal),
        .retired    (retired)
    );

    assign obsVec = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                     alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, halted, illegal};

    // Free-running 10-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Reference control vector for one cycle, written from the control table
    function automatic logic [17:0] expectedVector(input phase_t p, input logic rdy,
                                                   input logic z, input logic [3:0] iop);
        logic mreq, mwe, io, irw, pcw, asa, rw, rd, m2r, h, ill;
        logic [1:0] pcs, asb;
        logic [2:0] aop;
        {mreq, mwe, io, irw, pcw, asa, rw, rd, m2r, h, ill} = '0;
        pcs = 2'b00;
        asb = 2'b00;
        aop = 3'b000;
        case (p)
            P_FETCH:    begin mreq = 1; asb = 2'b01; aop = 3'b010; irw = rdy; pcw = rdy; end
            P_DECODE:   begin asb = 2'b10; aop = 3'b010; end
            P_EXEC_R:   begin asa = 1; asb = 2'b00; aop = 3'b000; end
            P_EXEC_I:   begin
                asa = 1; asb = 2'b10;
                aop = (iop == 4'b0010) ? 3'b110 : (iop == 4'b0011) ? 3'b111 : 3'b010;
            end
            P_MEM_ADDR: begin asa = 1; asb = 2'b10; aop = 3'b010; end
            P_MEM_RD:   begin mreq = 1; io = 1; end
            P_MEM_WR:   begin mreq = 1; mwe = 1; io = 1; end
            P_WB_R:     begin rw = 1; rd = 1; end
            P_WB_I:     begin rw = 1; end
            P_WB_M:     begin rw = 1; m2r = 1; end
            P_BRANCH:   begin asa = 1; aop = 3'b011; pcs = 2'b01; pcw = z; end
            P_JUMP:     begin pcw = 1; pcs = 2'b10; end
            P_HALT:     begin h = 1; end
            P_ILL:      begin ill = 1; end
            default:    begin end
        endcase
        return {mreq, mwe, io, irw, pcw, pcs, asa, asb, aop, rw, rd, m2r, h, ill};
    endfunction

    // Drive one cycle of inputs, push its expectation and advance to the next cycle
    task automatic applyStimulus(input phase_t ph, input logic rdy, input logic z,
                                 input logic [3:0] op, input string tag);
        sbEntry_t e;
        mem_ready = rdy;
        zero      = z;
        opcode    = op;
        e.tag = tag;
        e.vec = expectedVector(ph, rdy, z, latchedOp);
        e.ret = expRetired;
        sb.push_back(e);
        if (ph inside {P_WB_R, P_WB_I, P_WB_M, P_BRANCH, P_JUMP} || (ph == P_MEM_WR && rdy))
            expRetired = expRetired + 1'b1;
        if (ph == P_DECODE) latchedOp = op;
        @(posedge clk);
        #1;
    endtask

    // Run a whole instruction; opcode is noise outside DECODE to exercise the latch
    task automatic runInstr(input logic [3:0] op, input logic z, input int fetchWait,
                            input int memWait, input string tag);
        for (int i = 0; i < fetchWait; i++) applyStimulus(P_FETCH, 1'b0, 1'b1, 4'hA, tag);
        applyStimulus(P_FETCH, 1'b1, 1'b1, 4'hA, tag);
        applyStimulus(P_DECODE, 1'b1, 1'b1, op, tag);
        case (op)
            4'b0000: begin
                applyStimulus(P_EXEC_R, 1'b1, 1'b1, 4'hA, tag);
                applyStimulus(P_WB_R, 1'b1, 1'b1, 4'hA, tag);
            end
            4'b0001, 4'b0010, 4'b0011: begin
                applyStimulus(P_EXEC_I, 1'b1, 1'b1, 4'hA, tag);
                applyStimulus(P_WB_I, 1'b1, 1'b1, 4'hA, tag);
            end
            4'b0100: begin
                applyStimulus(P_MEM_ADDR, 1'b1, 1'b1, 4'hA, tag);
                for (int i = 0; i < memWait; i++) applyStimulus(P_MEM_RD, 1'b0, 1'b1, 4'hA, tag);
                applyStimulus(P_MEM_RD, 1'b1, 1'b1, 4'hA, tag);
                applyStimulus(P_WB_M, 1'b1, 1'b1, 4'hA, tag);
            end
            4'b0101: begin
                applyStimulus(P_MEM_ADDR, 1'b1, 1'b1, 4'hA, tag);
                for (int i = 0; i < memWait; i++) applyStimulus(P_MEM_WR, 1'b0, 1'b1, 4'hA, tag);
                applyStimulus(P_MEM_WR, 1'b1, 1'b1, 4'hA, tag);
            end
            4'b0110: applyStimulus(P_BRANCH, 1'b1, z, 4'hA, tag);
            4'b0111: applyStimulus(P_JUMP, 1'b1, 1'b1, 4'hA, tag);
            4'b1111: for (int i = 0; i < 3; i++) applyStimulus(P_HALT, i[0], 1'b1, 4'h0, tag);
            default: for (int i = 0; i < 3; i++) applyStimulus(P_ILL, i[0], 1'b1, 4'h0, tag);
        endcase
    endtask

    // Assert reset, check outputs clear asynchronously, release at posedge+1
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        #1;
        checkOutput({tag, "/ctrl"}, 32'(obsVec), 32'd0);
        checkOutput({tag, "/retired"}, 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        expRetired = '0;
        latchedOp  = '0;
    endtask

    // Mid-cycle monitor: pop the expectation for this cycle and compare
    always @(negedge clk) begin
        if (rst_n && sb.size() > 0) begin
            mon = sb.pop_front();
            checkOutput({mon.tag, "/ctrl"}, 32'(obsVec), 32'(mon.vec));
            checkOutput({mon.tag, "/retired"}, 32'(retired), 32'(mon.ret));
        end
    end

    // Main stimulus sequence
    initial begin
        testsRun   = 0;
        failCount  = 0;
        expRetired = '0;
        latchedOp  = '0;
        opcode     = 4'h0;
        zero       = 1'b0;
        mem_ready  = 1'b0;
        rst_n      = 1'b1;
        #2;
        doReset("reset0");
        applyStimulus(P_FETCH, 1'b0, 1'b0, 4'hA, "idle");
        runInstr(4'b0000, 1'b0, 0, 0, "rtype");
        runInstr(4'b0100, 1'b0, 0, 3, "lw");
        runInstr(4'b0110, 1'b1, 0, 0, "beq_taken");
        runInstr(4'b0110, 1'b0, 0, 0, "beq_not");
        runInstr(4'b0010, 1'b0, 0, 0, "andi");
        runInstr(4'b0011, 1'b0, 0, 0, "ori");
        runInstr(4'b0101, 1'b0, 2, 2, "sw");
        runInstr(4'b0001, 1'b0, 0, 0, "addi");
        runInstr(4'b0111, 1'b0, 0, 0, "jump");
        applyStimulus(P_FETCH, 1'b0, 1'b0, 4'hA, "after_jump");

        // Abandon a load in MEM_RD: mem_req must fall without a clock edge
        applyStimulus(P_FETCH, 1'b1, 1'b0, 4'hA, "abandon");
        applyStimulus(P_DECODE, 1'b1, 1'b0, 4'b0100, "abandon");
        applyStimulus(P_MEM_ADDR, 1'b1, 1'b0, 4'hA, "abandon");
        applyStimulus(P_MEM_RD, 1'b0, 1'b0, 4'hA, "abandon");
        checkOutput("abandon/mem_req_before", 32'(mem_req), 32'd1);
        #2;
        doReset("reset_mid_rd");
        applyStimulus(P_FETCH, 1'b0, 1'b0, 4'hA, "post_reset");

        runInstr(4'b0111, 1'b0, 0, 0, "pre_illegal");
        runInstr(4'b1010, 1'b0, 0, 0, "illegal");
        doReset("reset_ill");
        runInstr(4'b0111, 1'b0, 0, 0, "pre_halt");
        runInstr(4'b1111, 1'b0, 0, 0, "halt");
        doReset("reset_halt");

        for (int i = 0; i < 16; i++) runInstr(4'b0111, 1'b0, 0, 0, "wrap_j");
        applyStimulus(P_FETCH, 1'b0, 1'b0, 4'hA, "wrapped");

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
